// File: rtl/morse_seq_pkg.sv
// morse_seq_pkg: shared state type, code field layout and Morse unit lengths
package morse_seq_pkg;
    typedef enum logic [2:0] {IDLE, ARM, MARK, SPACE, CGAP, WGAP, HOLD} state_t;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 5;
    localparam int PAT_W = 5;
    localparam int DIT_U = 1;
    localparam int DAH_U = 3;
    localparam int EGAP_U = 1;
    localparam int CGAP_U = 2;
    localparam int WGAP_U = 4;
endpackage

// File: rtl/morse_msg_sequencer.sv
// morse_msg_sequencer: memory-keyer playback of coded characters, paced by the dit strobe
// Define FARNSWORTH_EN to stretch character/word gaps by farns_extra_i units.
module morse_msg_sequencer
    import morse_seq_pkg::*;
#(
    parameter int HOLDOFF_UNITS = 7,
    parameter int CNT_W = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       tick_i,
    input  logic       char_valid_i,
    input  logic [7:0] char_data_i,
    output logic       char_ready_o,
    input  logic       manual_active_i,
    input  logic [3:0] farns_extra_i,
    output logic       key_o,
    output logic       busy_o,
    output logic       aborted_o,
    output logic       code_err_o
);
    // Wide enough for the longest stretched word gap (4 + 2*15).
    localparam int CW = (CNT_W < 6) ? 6 : CNT_W;
    state_t state;
    logic [CW-1:0] cnt;
    logic [PAT_W-1:0] sr;
    logic [2:0] rem;
    logic run;
    logic [2:0] len;
    logic [CW-1:0] cgap_n;
    logic [CW-1:0] wgap_n;
    assign len = char_data_i[LEN_MSB:LEN_LSB];
    assign busy_o = state != IDLE;
    assign char_ready_o = run && state == IDLE && !manual_active_i;
`ifdef FARNSWORTH_EN
    logic [3:0] fx;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            fx <= '0;
        else if (char_valid_i && char_ready_o)
            fx <= farns_extra_i;
    end
    assign cgap_n = CW'(CGAP_U) + CW'(fx);
    assign wgap_n = CW'(WGAP_U) + CW'({fx, 1'b0});
`else
    logic unused_farns;
    assign unused_farns = ^farns_extra_i;
    assign cgap_n = CW'(CGAP_U);
    assign wgap_n = CW'(WGAP_U);
`endif
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            rem <= '0;
            run <= 1'b0;
            key_o <= 1'b0;
            aborted_o <= 1'b0;
            code_err_o <= 1'b0;
        end else begin
            run <= 1'b1;
            aborted_o <= 1'b0;
            code_err_o <= 1'b0;
            if (manual_active_i && state != IDLE && state != HOLD) begin
                state <= HOLD;
                cnt <= CW'(HOLDOFF_UNITS);
                sr <= '0;
                rem <= '0;
                key_o <= 1'b0;
                aborted_o <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (manual_active_i) begin
                            state <= HOLD;
                            cnt <= CW'(HOLDOFF_UNITS);
                        end else if (char_valid_i && run) begin
                            if (len > 3'd5) begin
                                code_err_o <= 1'b1;
                            end else begin
                                sr <= char_data_i[PAT_W-1:0];
                                rem <= len;
                                state <= ARM;
                            end
                        end
                    end
                    ARM: begin
                        if (tick_i && rem == 3'd0) begin
                            state <= WGAP;
                            cnt <= wgap_n;
                        end else if (tick_i) begin
                            state <= MARK;
                            key_o <= 1'b1;
                            cnt <= sr[0] ? CW'(DAH_U) : CW'(DIT_U);
                        end
                    end
                    MARK: begin
                        if (tick_i && cnt <= CW'(1)) begin
                            state <= SPACE;
                            key_o <= 1'b0;
                            cnt <= CW'(EGAP_U);
                        end else if (tick_i) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    SPACE: begin
                        if (tick_i && cnt <= CW'(1) && rem > 3'd1) begin
                            state <= MARK;
                            key_o <= 1'b1;
                            sr <= sr >> 1;
                            rem <= rem - 3'd1;
                            cnt <= sr[1] ? CW'(DAH_U) : CW'(DIT_U);
                        end else if (tick_i && cnt <= CW'(1)) begin
                            state <= CGAP;
                            sr <= '0;
                            rem <= '0;
                            cnt <= cgap_n;
                        end else if (tick_i) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    CGAP, WGAP: begin
                        if (tick_i && cnt <= CW'(1)) begin
                            state <= IDLE;
                            cnt <= '0;
                        end else if (tick_i) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    HOLD: begin
                        if (manual_active_i) begin
                            cnt <= CW'(HOLDOFF_UNITS);
                        end else if (tick_i && cnt <= CW'(1)) begin
                            state <= IDLE;
                            cnt <= '0;
                        end else if (tick_i) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_morse_msg_sequencer.sv
// tb_morse_msg_sequencer: directed checks of playback timing, preemption, errors and reset
module tb_morse_msg_sequencer;
`ifdef FARNSWORTH_EN
    localparam int CG = 5;
    localparam int WG = 10;
`else
    localparam int CG = 2;
    localparam int WG = 4;
`endif
    logic clk_i = 1'b0;
    logic rstn_i = 1'b1;
    logic tick_i = 1'b0;
    logic char_valid_i = 1'b0;
    logic [7:0] char_data_i = 8'h00;
    logic char_ready_o;
    logic manual_active_i = 1'b0;
    logic [3:0] farns_extra_i = 4'd3;
    logic key_o;
    logic busy_o;
    logic aborted_o;
    logic code_err_o;
    int passed = 0;
    int total = 0;
    int n;
    logic k;
    logic [5:0] kv;

    morse_msg_sequencer dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .tick_i(tick_i),
        .char_valid_i(char_valid_i),
        .char_data_i(char_data_i),
        .char_ready_o(char_ready_o),
        .manual_active_i(manual_active_i),
        .farns_extra_i(farns_extra_i),
        .key_o(key_o),
        .busy_o(busy_o),
        .aborted_o(aborted_o),
        .code_err_o(code_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // One dit unit: strobe on the first cycle, then nine quiet cycles.
    task automatic tick_unit();
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
        repeat (9) cyc();
    endtask

    task automatic send(input logic [7:0] c);
        char_data_i = c;
        char_valid_i = 1'b1;
        cyc();
        char_valid_i = 1'b0;
    endtask

    // Counts units until busy drops (bounded), noting whether key rose meanwhile.
    task automatic idle_wait(output int cnt, output logic keyed);
        cnt = 0;
        keyed = 1'b0;
        while (busy_o && cnt < 40) begin
            tick_unit();
            keyed = keyed | key_o;
            cnt++;
        end
    endtask

    initial begin
        #2 rstn_i = 1'b0;
        repeat (3) cyc();
        check("rst_key", key_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", char_ready_o, 0);
        check("rst_abort", aborted_o, 0);
        check("rst_err", code_err_o, 0);
        rstn_i = 1'b1;
        repeat (2) cyc();
        check("ready_after_rst", char_ready_o, 1);

        send(8'h42);
        check("a_busy_arm", busy_o, 1);
        check("a_ready_arm", char_ready_o, 0);
        check("a_key_arm", key_o, 0);
        for (int i = 0; i < 6; i++) begin
            tick_unit();
            kv[i] = key_o;
        end
        check("a_key_pattern", int'(kv), int'(6'b011101));
        idle_wait(n, k);
        check("a_cgap_units", n, 1 + CG);
        check("a_ready_back", char_ready_o, 1);

        send(8'h20);
        idle_wait(n, k);
        check("e_units", n, 3 + CG);
        check("e_keyed", k, 1);
        send(8'h00);
        check("wgap_busy", busy_o, 1);
        idle_wait(n, k);
        check("wgap_units", n, 1 + WG);
        check("wgap_silent", k, 0);

        send(8'hBF);
        tick_unit();
        tick_unit();
        check("zero_mid_dah", key_o, 1);
        manual_active_i = 1'b1;
        cyc();
        check("abort_key", key_o, 0);
        check("abort_pulse", aborted_o, 1);
        check("abort_busy", busy_o, 1);
        cyc();
        check("abort_one_shot", aborted_o, 0);
        tick_unit();
        tick_unit();
        check("hold_busy_manual", busy_o, 1);
        check("hold_ready_manual", char_ready_o, 0);
        manual_active_i = 1'b0;
        for (int i = 0; i < 4; i++) tick_unit();
        manual_active_i = 1'b1;
        cyc();
        check("blip_no_pulse", aborted_o, 0);
        manual_active_i = 1'b0;
        idle_wait(n, k);
        check("holdoff_restart", n, 7);
        check("hold_no_key", k, 0);
        check("hold_ready", char_ready_o, 1);

        manual_active_i = 1'b1;
        cyc();
        check("idle_hold_busy", busy_o, 1);
        check("idle_hold_nopulse", aborted_o, 0);
        manual_active_i = 1'b0;
        idle_wait(n, k);
        check("idle_holdoff", n, 7);

        send(8'hE0);
        check("err_pulse", code_err_o, 1);
        check("err_busy", busy_o, 0);
        cyc();
        check("err_one_shot", code_err_o, 0);
        check("err_ready", char_ready_o, 1);
        tick_unit();
        tick_unit();
        check("err_no_key", key_o, 0);

        send(8'h42);
        tick_unit();
        check("r_key_mark", key_o, 1);
        rstn_i = 1'b0;
        #1;
        check("r_async_key", key_o, 0);
        check("r_async_busy", busy_o, 0);
        repeat (2) cyc();
        rstn_i = 1'b1;
        repeat (2) cyc();
        check("r_ready", char_ready_o, 1);
        tick_unit();
        tick_unit();
        check("r_no_replay_key", key_o, 0);
        check("r_no_replay_busy", busy_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
